game_mode_ctrl: RTL and testbench
=================================

# game_mode_ctrl

Top-level game-mode controller for the board's game console. It debounces the two raw active-low push buttons (select, start), sequences the one-hot game selection 0001→0010→0100→1000→0001, and runs a per-round countdown timer. It also tracks the console state (idle, selecting, running, over) and issues a one-cycle `game_charge` pulse on every selection change. `game` feeds the per-game datapaths; `game_over_in` comes back from them.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000 — consecutive stable cycles required to accept a button level change (1 ms at 50 MHz); must be ≥2.
- `TICK_CYCLES`, default 50000000 — clock cycles per countdown second; must be ≥2.
- `ROUND_SECONDS`, default 60 — round length in seconds; 1..127.

Ports:
- `clk` in 1 — single system clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `btn_select_n` in 1 — raw select button, active-low, asynchronous to `clk`.
- `btn_start_n` in 1 — raw start button, active-low, asynchronous to `clk`.
- `game_over_in` in 1 — level from the game logic; ends the round early.
- `game` out 4 — one-hot selected game; 0000 means none selected.
- `game_charge` out 1 — one-cycle pulse when `game` changes.
- `game_active` out 1 — high while the round is running and not paused.
- `time_left` out 7 — remaining seconds in the round.
- `state` out 2 — 00 IDLE, 01 SELECT, 10 RUN, 11 OVER.
- `paused` out 1 — pause flag; tied 0 when the pause feature is compiled out.

## Operation
- **Debounce (per button):**
  - 2-flop synchronizer feeds a counter.
  - The counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the levels still differing, the debounced level updates.
  - A registered press event pulses for one cycle on each debounced high→low transition. Releases produce no event.
- **IDLE:**
  - Select press → `game`=0001, `game_charge` pulse, go to SELECT.
  - Start press is ignored.
- **SELECT:**
  - Select press → rotate `game` one position left, wrapping 1000→0001, with a `game_charge` pulse.
  - Start press → go to RUN; load `time_left`=`ROUND_SECONDS`; clear the tick counter.
  - Select and start pressed in the same cycle: start wins, no rotation.
- **RUN:**
  - `game` is locked; select presses are ignored.
  - The tick counter counts 0..`TICK_CYCLES-1`. On wrap, `time_left` decrements.
  - When the decrement takes `time_left` from 1 to 0, move to OVER on the same edge.
  - `game_over_in` high → OVER on the next edge, with `time_left` frozen. This has priority over a simultaneous tick and over pause.
- **OVER:**
  - `game` and `time_left` are held.
  - Select or start press → SELECT with `game` unchanged and no `game_charge` pulse.
- `game_active` = (state==RUN) && !`paused`.
- Any encoding outside the defined `game` values or states recovers to reset values on the next edge.

## Timing
- Reset values: `game`=0000, `state`=00, `game_charge`=0, `game_active`=0, `time_left`=0, `paused`=0; all debounced levels released; all counters 0.
- Reset is asynchronous and can be asserted mid-round; outputs take reset values immediately.
- Press latency: a raw button held low from edge k produces its event at edge k+2+`DEBOUNCE_CYCLES`+1 (±1). State and outputs update on the same edge as the event.
- Pulses shorter than `DEBOUNCE_CYCLES` synced cycles produce no event.
- `game_charge` is high exactly in the cycle `game` shows its new value.
- In RUN, `time_left` decrements every `TICK_CYCLES` cycles, the first time `TICK_CYCLES` cycles after entering RUN. A round lasts exactly `ROUND_SECONDS`×`TICK_CYCLES` cycles.

## Configuration
- `GAME_CTRL_PAUSE_EN` defined:
  - In RUN, a start press toggles `paused`.
  - While paused, the tick counter and `time_left` freeze and `game_active`=0.
  - `game_over_in` still moves to OVER and clears `paused`.
  - A tick wrap and an unpause in the same cycle cannot occur, because the counter is frozen while paused.
- `GAME_CTRL_PAUSE_EN` undefined:
  - Start presses in RUN are ignored.
  - `paused` is tied 0 and no pause logic is present.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `TICK_CYCLES`=10, `ROUND_SECONDS`=3.

1. Reset, then 5 clean select presses → `game` steps 0001, 0010, 0100, 1000, 0001; 5 `game_charge` pulses; `state`=01.
2. `btn_select_n` low for 2 cycles, plus bounce toggling each cycle for 10 cycles before a stable press → `game` unchanged by the short pulse and bounce; exactly one rotation on the stable press.
3. Start in SELECT with `game`=0100:
   - `state`=10, `time_left`=3, `game_active`=1.
   - `time_left` reads 2, 1, 0 at +10, +20, +30 cycles; `state`=11 at +30.
   - Select presses during RUN leave `game`=0100.
4. `game_over_in` pulse at cycle 15 of RUN → `state`=11 next edge, `time_left`=2. Then a start press → `state`=01, `game`=0100, no `game_charge` pulse.
5. `reset_n` low mid-RUN → all outputs go to reset values immediately (asynchronously). After release, a select press gives `game`=0001.
6. With `GAME_CTRL_PAUSE_EN`: start press at cycle 5 of RUN holds `time_left`=3 and `game_active`=0 for 50 cycles; a second press resumes, and OVER is reached 25 cycles later. Without the macro: the same stimulus leaves `paused`=0 and OVER is reached at cycle 30.

Source files
------------

// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: debounced select/start, one-hot game rotation and round timer; define GAME_CTRL_PAUSE_EN to add pause
module game_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_CYCLES = 50000000,
  parameter int ROUND_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_select_n,
  input  logic       btn_start_n,
  input  logic       game_over_in,
  output logic [3:0] game,
  output logic       game_charge,
  output logic       game_active,
  output logic [6:0] time_left,
  output logic [1:0] state,
  output logic       paused
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
  localparam logic [6:0] ROUND = 7'(ROUND_SECONDS);
  typedef enum logic [1:0] {IDLE = 2'b00, SEL = 2'b01, RUN = 2'b10, OVER = 2'b11} state_t;
  state_t st_q, st_d;
  logic [1:0] s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, press_q, press_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [3:0] game_q, game_d;
  logic charge_q, charge_d;
  logic [6:0] time_q, time_d;
  logic [TW-1:0] tick_q, tick_d;
  logic sel_p, start_p, game_ok, tick_wrap, run_en;
  assign sel_p = press_q[0];
  assign start_p = press_q[1];
  assign game_ok = game_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  assign tick_wrap = tick_q == TICK_MAX;
  // synchronize both buttons and accept a level only after it has been stable long enough
  always_comb begin
    s1_d = {btn_start_n, btn_select_n};
    s2_d = s1_q;
    deb_d = deb_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] != deb_q[i]) ? cnt_q[i] + 1'b1 : '0;
      if (s2_q[i] != deb_q[i] && cnt_q[i] == DB_MAX) begin
        cnt_d[i] = '0;
        deb_d[i] = s2_q[i];
        press_d[i] = !s2_q[i];
      end
    end
  end
`ifdef GAME_CTRL_PAUSE_EN
  logic pause_q, pause_d;
  // start toggles pause while the round keeps running; leaving RUN always clears it
  always_comb pause_d = (st_q == RUN && st_d == RUN) ? pause_q ^ start_p : 1'b0;
  // pause flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pause_q <= 1'b0;
    else pause_q <= pause_d;
  end
  assign run_en = !pause_q;
  assign paused = pause_q;
`else
  assign run_en = 1'b1;
  assign paused = 1'b0;
`endif
  // console sequencing: selection, round start, countdown and game over
  always_comb begin
    st_d = st_q;
    game_d = game_q;
    time_d = time_q;
    tick_d = tick_q;
    case (st_q)
      IDLE: begin
        st_d = sel_p ? SEL : IDLE;
        game_d = sel_p ? 4'b0001 : game_q;
      end
      SEL: begin
        st_d = start_p ? RUN : SEL;
        game_d = (sel_p && !start_p) ? {game_q[2:0], game_q[3]} : game_q;
        time_d = start_p ? ROUND : time_q;
        tick_d = start_p ? '0 : tick_q;
      end
      RUN: begin
        st_d = game_over_in ? OVER : RUN;
        if (!game_over_in && run_en) begin
          tick_d = tick_wrap ? '0 : tick_q + 1'b1;
          time_d = tick_wrap ? time_q - 1'b1 : time_q;
          st_d = (tick_wrap && time_q == 7'd1) ? OVER : RUN;
        end
      end
      OVER: st_d = (sel_p || start_p) ? SEL : OVER;
    endcase
    if (!game_ok) begin
      st_d = IDLE;
      game_d = '0;
      time_d = '0;
      tick_d = '0;
    end
    charge_d = game_ok && game_d != game_q;
  end
  // debounce, state and timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      deb_q <= 2'b11;
      press_q <= 2'b00;
      cnt_q <= '{default: '0};
      st_q <= IDLE;
      game_q <= '0;
      charge_q <= 1'b0;
      time_q <= '0;
      tick_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      deb_q <= deb_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
      game_q <= game_d;
      charge_q <= charge_d;
      time_q <= time_d;
      tick_q <= tick_d;
    end
  end
  assign game = game_q;
  assign game_charge = charge_q;
  assign time_left = time_q;
  assign state = st_q;
  assign game_active = st_q == RUN && !paused;
endmodule

// File: tb/tb_game_mode_ctrl.sv
// tb_game_mode_ctrl: directed and randomized button stimulus checked every cycle against a reference model
module tb_game_mode_ctrl;
  localparam int DB = 4;
  localparam int TK = 10;
  localparam int RS = 3;
`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n, btn_select_n, btn_start_n, game_over_in;
  logic [3:0] game;
  logic game_charge, game_active, paused;
  logic [6:0] time_left;
  logic [1:0] state;
  int n_vec = 0;
  int n_bad = 0;
  int m_st, m_g, m_tl, m_rc;
  bit m_pz, m_charge;
  bit [1:0] m_d1, m_d2, m_lvl, m_ev;
  int m_run [2];

  game_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_CYCLES(TK), .ROUND_SECONDS(RS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_select_n(btn_select_n),
    .btn_start_n(btn_start_n),
    .game_over_in(game_over_in),
    .game(game),
    .game_charge(game_charge),
    .game_active(game_active),
    .time_left(time_left),
    .state(state),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0;
    m_g = -1;
    m_tl = 0;
    m_rc = 0;
    m_pz = 1'b0;
    m_charge = 1'b0;
    m_d1 = 2'b11;
    m_d2 = 2'b11;
    m_lvl = 2'b11;
    m_ev = 2'b00;
    m_run[0] = 0;
    m_run[1] = 0;
  endtask

  // one clock edge of the reference: index 0 = select, 1 = start; states 0 idle, 1 select, 2 run, 3 over
  task automatic m_step();
    bit sp, tp, npz, seen;
    bit [1:0] raw;
    sp = m_ev[0];
    tp = m_ev[1];
    raw = {btn_start_n, btn_select_n};
    for (int b = 0; b < 2; b++) begin
      seen = m_d2[b];
      m_d2[b] = m_d1[b];
      m_d1[b] = raw[b];
      m_ev[b] = 1'b0;
      if (seen != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b] = seen;
          m_run[b] = 0;
          m_ev[b] = !seen;
        end
      end else m_run[b] = 0;
    end
    m_charge = 1'b0;
    npz = m_pz;
    case (m_st)
      0: if (sp) begin
        m_g = 0;
        m_charge = 1'b1;
        m_st = 1;
      end
      1: if (tp) begin
        m_st = 2;
        m_tl = RS;
        m_rc = 0;
      end else if (sp) begin
        m_g = (m_g + 1) % 4;
        m_charge = 1'b1;
      end
      2: if (game_over_in) begin
        m_st = 3;
        npz = 1'b0;
      end else begin
        if (PAUSE && tp) npz = !m_pz;
        if (!m_pz) begin
          m_rc++;
          if (m_rc % TK == 0) begin
            m_tl--;
            if (m_tl == 0) begin
              m_st = 3;
              npz = 1'b0;
            end
          end
        end
      end
      default: if (sp || tp) m_st = 1;
    endcase
    m_pz = npz;
  endtask

  task automatic check_all();
    check("game", game, (m_g < 0) ? 0 : (1 << m_g));
    check("game_charge", game_charge, m_charge);
    check("game_active", game_active, (m_st == 2 && !m_pz) ? 1 : 0);
    check("time_left", time_left, m_tl);
    check("state", state, m_st);
    check("paused", paused, m_pz);
  endtask

  task automatic cyc(input bit s, input bit t, input bit g);
    btn_select_n = s;
    btn_start_n = t;
    game_over_in = g;
    @(negedge clk);
    if (reset_n) m_step();
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic press(input bit s, input bit t);
    repeat (DB + 2 + $urandom_range(0, 3)) cyc(s, t, 1'b0);
    idle(DB + 4 + $urandom_range(0, 3));
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    m_reset();
    #1 check_all();
    idle(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    btn_select_n = 1'b1;
    btn_start_n = 1'b1;
    game_over_in = 1'b0;
    m_reset();
    #2 reset_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    idle(3);
    reset_n = 1'b1;
    repeat (5) press(1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    idle(6);
    for (int i = 0; i < 10; i++) cyc(i[0], 1'b1, 1'b0);
    idle(6);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    idle(3);
    press(1'b0, 1'b1);
    idle(30);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    idle(8);
    cyc(1'b1, 1'b1, 1'b1);
    idle(5);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    idle(10);
    async_reset();
    press(1'b0, 1'b1);
    press(1'b0, 1'b0);
    idle(40);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    idle(2);
    press(1'b1, 1'b0);
    idle(50);
    press(1'b1, 1'b0);
    idle(40);
    for (int n = 0; n < 400; n++) begin
      bit s, t, g;
      s = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 12)) cyc(s, t, g);
      if (n == 200) async_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
